ring_sum_sorter: RTL and testbench
==================================

# ring_sum_sorter

Parametrised two-ring add-and-sort engine. It accepts two rings of N unsigned W-bit pixels with a rotation offset per ring, and forms the element-wise sum of ring A against ring B realigned by that offset. It sorts the N sums in a selectable direction and streams them out one per cycle. It is the generalised successor of the fixed 8-pixel, 5-bit circle adder/sorter, and sits behind the same serial pixel loader in the lab datapath.

## Interface

Parameters:
- N, 8, ring length; power of two, 2..64.
- W, 5, pixel width in bits.
- IW, $clog2(N), rotation/index width (derived, not overridden).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input word qualifier.
- in  in  W  pixel word; first N accepted words are ring A[0..N-1], next N are ring B[0..N-1].
- circle1  in  IW  ring A rotation; sampled only with the first accepted word of a frame.
- circle2  in  IW  ring B rotation; sampled only with the first accepted word.
- mode  in  1  0 = ascending, 1 = descending; sampled only with the first accepted word.
- in_ready  out  1  high when a word can be accepted.
- out_valid  out  1  result qualifier.
- out  out  W+1  sorted sum.
- out_idx  out  IW  original ring A index of the current sum; present only with RSS_INDEX_OUT_EN.

## Operation

- FSM states:
  - IDLE → LOAD (first accepted word).
  - LOAD → ADD (2N-th word accepted).
  - ADD → SORT (1 cycle).
  - SORT → OUT (exactly N cycles).
  - OUT → IDLE (exactly N cycles).
- Word acceptance: a word is accepted on a clock edge where in_valid && in_ready. in_ready = 1 in IDLE and LOAD, 0 otherwise.
- Gaps allowed during LOAD: in_valid low holds the word count and the stored data, and loading resumes on the next accepted word. No timeout.
- in_valid while in_ready = 0 is ignored. It does not start a new frame.
- ADD: sum[i] = A[i] + B[(i + circle1 − circle2) mod N], with modulo-N wrap in IW bits. Full W+1-bit result, no saturation.
- SORT: odd-even transposition, one compare-exchange stage per cycle for N cycles; stage k uses even pairs if k is even, odd pairs otherwise.
  - Ascending swaps on strictly greater; descending swaps on strictly less.
  - Equal sums keep original index order (stable), including in descending mode.
- OUT: emits the sorted element at position 0, 1, …, N−1 on consecutive cycles.
- When out_valid = 0, out = 0 and out_idx = 0.

## Timing

- Reset values: out_valid = 0, out = 0, out_idx = 0, in_ready = 1, FSM = IDLE, word count = 0.
- Latency: out_valid rises N+2 cycles after the edge that accepted the last word, measured edge to edge. It then stays high exactly N consecutive cycles.
- in_ready falls the cycle after the 2N-th acceptance. It rises the cycle after the last out_valid beat, so a new frame can begin immediately after.
- rst asserted in any state: on that edge the FSM returns to IDLE, the partial frame is discarded, and all outputs take reset values. There is no residual output after rst.
- rst and in_valid asserted on the same edge: rst wins and the word is not accepted.

## Configuration

- RSS_INDEX_OUT_EN defined: the out_idx port exists. Each sum register carries its IW-bit source index through SORT, and out_idx is valid alongside out.
- RSS_INDEX_OUT_EN undefined: there is no out_idx port and no index registers. Sums and timing are identical.

## Test plan

- N=8, W=5, all pixels 31, c1=c2=0, mode 0 → eight beats of 62; out_valid 10 cycles after the last word.
- A=B=0..7, c1=c2=0, mode 0 → 0,2,4,6,8,10,12,14.
- A=B=0..7, c1=3, c2=1:
  - mode 0 → 2,4,6,6,8,8,10,12, with out_idx 0,1,2,6,3,7,4,5.
  - mode 1 → 12,10,8,8,6,6,4,2, with out_idx 5,4,3,7,2,6,1,0.
- Same frame with in_valid low for 3 cycles inside ring A and 2 cycles inside ring B → identical output, and latency from the last word is still 10. in_valid held high during OUT → ignored, no second frame.
- rst pulsed for 1 cycle in SORT → out_valid=0 and out=0 from the next cycle. A following all-31 frame then yields eight beats of 62.
- N=16, W=8, 200 random frames with random rotations and mode → match the reference model (rotate, add, stable sort). out_valid runs exactly 16 beats, with latency 18.

Source files
------------

// File: rtl/ring_sum_sorter.sv
// Two-ring add-and-sort engine: loads rings A and B serially, adds A against a rotated B,
// sorts the N sums by odd-even transposition and streams them out. Define RSS_INDEX_OUT_EN for out_idx.
module ring_sum_sorter #(
  parameter int N  = 8,
  parameter int W  = 5,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  in,
  input  logic [IW-1:0] circle1,
  input  logic [IW-1:0] circle2,
  input  logic          mode,
  output logic          in_ready,
  output logic          out_valid,
  output logic [W:0]    out
`ifdef RSS_INDEX_OUT_EN
  ,
  output logic [IW-1:0] out_idx
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ADD,
    S_SORT,
    S_OUT
  } state_t;

  localparam int CW = IW + 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(2 * N - 1);
  localparam logic [CW-1:0] LAST_ELEM = CW'(N - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] off_q, off_d;
  logic          mode_q, mode_d;
  logic          out_valid_q, out_valid_d;
  logic [W:0]    out_q, out_d;
  logic          accept;

  logic [W-1:0]  a_q   [N];
  logic [W-1:0]  b_q   [N];
  logic [W:0]    sum_q [N];
  logic [W:0]    sum_d [N];

`ifdef RSS_INDEX_OUT_EN
  logic [IW-1:0] idx_q [N];
  logic [IW-1:0] idx_d [N];
  logic [IW-1:0] out_idx_q, out_idx_d;
`endif

  // The trailing output beat lands in IDLE, so hold off a new frame until it has left.
  assign in_ready  = ((state_q == S_IDLE) || (state_q == S_LOAD)) && !out_valid_q;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out       = out_q;
`ifdef RSS_INDEX_OUT_EN
  assign out_idx   = out_idx_q;
`endif

  // cnt_q is shared: word count in LOAD, stage number in SORT, read pointer in OUT.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    mode_d      = mode_q;
    out_valid_d = 1'b0;
    out_d       = '0;
`ifdef RSS_INDEX_OUT_EN
    out_idx_d   = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_LOAD;
          cnt_d   = CW'(1);
          off_d   = circle1 - circle2;
          mode_d  = mode;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (cnt_q == LAST_WORD) begin
            state_d = S_ADD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_ADD: state_d = S_SORT;
      S_SORT: begin
        if (cnt_q == LAST_ELEM) begin
          state_d = S_OUT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OUT: begin
        out_valid_d = 1'b1;
        out_d       = sum_q[cnt_q[IW-1:0]];
`ifdef RSS_INDEX_OUT_EN
        out_idx_d   = idx_q[cnt_q[IW-1:0]];
`endif
        if (cnt_q == LAST_ELEM) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      off_q       <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
`ifdef RSS_INDEX_OUT_EN
      out_idx_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
`ifdef RSS_INDEX_OUT_EN
      out_idx_q   <= out_idx_d;
`endif
    end
  end

  // Pairs within one stage are disjoint, so all exchanges of a stage happen in parallel.
  // Swapping only on strict inequality keeps equal sums in their original order.
  always_comb begin
    sum_d = sum_q;
`ifdef RSS_INDEX_OUT_EN
    idx_d = idx_q;
`endif
    if (state_q == S_ADD) begin
      for (int i = 0; i < N; i++) begin
        sum_d[i] = {1'b0, a_q[i]} + {1'b0, b_q[IW'(i) + off_q]};
`ifdef RSS_INDEX_OUT_EN
        idx_d[i] = IW'(i);
`endif
      end
    end else if (state_q == S_SORT) begin
      for (int j = 0; j < N - 1; j++) begin
        if ((((j % 2) == 1) == cnt_q[0]) &&
            (mode_q ? (sum_q[j] < sum_q[j+1]) : (sum_q[j] > sum_q[j+1]))) begin
          sum_d[j]   = sum_q[j+1];
          sum_d[j+1] = sum_q[j];
`ifdef RSS_INDEX_OUT_EN
          idx_d[j]   = idx_q[j+1];
          idx_d[j+1] = idx_q[j];
`endif
        end
      end
    end
  end

  // NOTE: the pixel and sum arrays carry no reset; control state guarantees they are rewritten before being read.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (!cnt_q[IW]) a_q[cnt_q[IW-1:0]] <= in;
      else            b_q[cnt_q[IW-1:0]] <= in;
    end
    sum_q <= sum_d;
`ifdef RSS_INDEX_OUT_EN
    idx_q <= idx_d;
`endif
  end

endmodule

// File: tb/tb_ring_sum_sorter.sv
// Self-checking bench for ring_sum_sorter: N=8/W=5 directed frames and N=16/W=8 random frames,
// each compared every cycle against a rotate/add/stable-sort model with latency windows.
module tb_ring_sum_sorter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, v0, rdy0, ov0, m0;
  logic [4:0] in0;
  logic [2:0] c10, c20;
  logic [5:0] out0;
  logic       rst1, v1, rdy1, ov1, m1;
  logic [7:0] in1;
  logic [3:0] c11, c21;
  logic [8:0] out1;
`ifdef RSS_INDEX_OUT_EN
  logic [2:0] oi0;
  logic [3:0] oi1;
`endif

  ring_sum_sorter #(.N(8), .W(5)) u_dut8 (
    .clk(clk), .rst(rst0), .in_valid(v0), .in(in0), .circle1(c10), .circle2(c20),
    .mode(m0), .in_ready(rdy0), .out_valid(ov0), .out(out0)
`ifdef RSS_INDEX_OUT_EN
    , .out_idx(oi0)
`endif
  );

  ring_sum_sorter #(.N(16), .W(8)) u_dut16 (
    .clk(clk), .rst(rst1), .in_valid(v1), .in(in1), .circle1(c11), .circle2(c21),
    .mode(m1), .in_ready(rdy1), .out_valid(ov1), .out(out1)
`ifdef RSS_INDEX_OUT_EN
    , .out_idx(oi1)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  int stim_a [64];
  int stim_b [64];

  // Model state per DUT: expected sorted frame plus the cycle windows in which it is busy / emitting.
  int m_val     [2][64];
  int m_idx     [2][64];
  int m_busy_lo [2] = '{0, 0};
  int m_busy_hi [2] = '{0, 0};
  int m_out_lo  [2] = '{0, 0};
  int m_out_hi  [2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc %0d: got %0d expected %0d", name, d, cyc, act, exp);
    end
  endtask

  function automatic void model_load(input int d, input int n, input int c1, input int c2,
                                     input int md, input int acc);
    int s [64];
    int id[64];
    int off, ks, ki, j;
    off = (((c1 - c2) % n) + n) % n;
    for (int i = 0; i < n; i++) begin
      s[i]  = stim_a[i] + stim_b[(i + off) % n];
      id[i] = i;
    end
    for (int i = 1; i < n; i++) begin
      ks = s[i];
      ki = id[i];
      j  = i - 1;
      while (j >= 0 && (md != 0 ? ks > s[j] : ks < s[j])) begin
        s[j+1]  = s[j];
        id[j+1] = id[j];
        j--;
      end
      s[j+1]  = ks;
      id[j+1] = ki;
    end
    for (int i = 0; i < n; i++) begin
      m_val[d][i] = s[i];
      m_idx[d][i] = id[i];
    end
    m_busy_lo[d] = acc;
    m_busy_hi[d] = acc + 2 * n + 2;
    m_out_lo[d]  = acc + n + 2;
    m_out_hi[d]  = acc + 2 * n + 2;
  endfunction

  function automatic void model_abort(input int d, input int r);
    if (m_busy_hi[d] > r) m_busy_hi[d] = r;
    if (m_out_hi[d] > r)  m_out_hi[d]  = r;
  endfunction

  always @(negedge clk) begin : cmp
    logic [31:0] a_v, a_o, a_r, a_i;
    int  c, eo, ei;
    bit  ev, er;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        c = cyc;
        a_i = '0;
        if (d == 0) begin
          a_v = 32'(ov0); a_o = 32'(out0); a_r = 32'(rdy0);
`ifdef RSS_INDEX_OUT_EN
          a_i = 32'(oi0);
`endif
        end else begin
          a_v = 32'(ov1); a_o = 32'(out1); a_r = 32'(rdy1);
`ifdef RSS_INDEX_OUT_EN
          a_i = 32'(oi1);
`endif
        end
        ev = (c >= m_out_lo[d]) && (c < m_out_hi[d]);
        er = !((c >= m_busy_lo[d]) && (c < m_busy_hi[d]));
        eo = ev ? m_val[d][c - m_out_lo[d]] : 0;
        ei = ev ? m_idx[d][c - m_out_lo[d]] : 0;
        check("out_valid", d, a_v, 32'(ev));
        check("out", d, a_o, eo);
        check("in_ready", d, a_r, 32'(er));
`ifdef RSS_INDEX_OUT_EN
        check("out_idx", d, a_i, ei);
`else
        ei = ei + 0;
`endif
      end
    end
  end

  task automatic drive(input int d, input bit v, input int px, input int c1, input int c2, input int md);
    if (d == 0) begin
      v0 = v; in0 = px[4:0]; c10 = c1[2:0]; c20 = c2[2:0]; m0 = md[0];
    end else begin
      v1 = v; in1 = px[7:0]; c11 = c1[3:0]; c21 = c2[3:0]; m1 = md[0];
    end
  endtask

  task automatic set_rst(input int d, input bit r);
    if (d == 0) rst0 = r;
    else        rst1 = r;
  endtask

  // Loads one frame (optional gaps before word ga_pos of A and gb_pos of B), then watches its output window.
  task automatic run_frame(input int d, input int c1, input int c2, input int md,
                           input int ga_pos, input int ga_len, input int gb_pos, input int gb_len,
                           input bit hold, input int rst_after, input int lat_exp);
    int n = (d == 0) ? 8 : 16;
    int k = 0, guard = 0, acc, first = -1, beats = 0, px;
    bit rdy, ov, ga_done = 1'b0, gb_done = 1'b0;
    while (k < 2 * n && guard < 4 * n + 64) begin
      if (k == ga_pos && !ga_done) begin
        repeat (ga_len) begin
          drive(d, 1'b0, int'($urandom_range(0, 255)), 0, 0, 0);
          @(posedge clk); #1;
        end
        ga_done = 1'b1;
      end
      if (k == n + gb_pos && !gb_done) begin
        repeat (gb_len) begin
          drive(d, 1'b0, int'($urandom_range(0, 255)), 0, 0, 0);
          @(posedge clk); #1;
        end
        gb_done = 1'b1;
      end
      px = (k < n) ? stim_a[k] : stim_b[k - n];
      if (k == 0) drive(d, 1'b1, px, c1, c2, md);
      else drive(d, 1'b1, px, int'($urandom_range(0, n - 1)), int'($urandom_range(0, n - 1)),
                 int'($urandom_range(0, 1)));
      rdy = (d == 0) ? rdy0 : rdy1;
      @(posedge clk); #1;
      guard++;
      if (rdy) k++;
    end
    if (k < 2 * n) begin
      check("load_timeout", d, k, 2 * n);
      drive(d, 1'b0, 0, 0, 0, 0);
      return;
    end
    acc = cyc;
    model_load(d, n, c1, c2, md, acc);
    drive(d, hold, int'($urandom_range(0, 255)), 0, 0, 0);
    for (int t = 0; t < 2 * n + 2; t++) begin
      if (rst_after >= 0 && t == rst_after) begin
        set_rst(d, 1'b1);
        drive(d, 1'b1, int'($urandom_range(0, 31)), 0, 0, 0);
        model_abort(d, cyc + 1);
      end else if (rst_after >= 0 && t == rst_after + 1) begin
        set_rst(d, 1'b0);
        drive(d, 1'b0, 0, 0, 0, 0);
      end
      if (hold && t == 2 * n + 1) drive(d, 1'b0, 0, 0, 0, 0);
      ov = (d == 0) ? ov0 : ov1;
      if (ov) begin
        beats++;
        if (first < 0) first = t;
      end
      @(posedge clk); #1;
    end
    if (lat_exp > 0) begin
      check("latency", d, first, lat_exp);
      check("beat_count", d, beats, n);
    end
    if (rst_after >= 0) check("beats_after_rst", d, beats, 0);
  endtask

  task automatic fill(input int n, input int kind);
    for (int i = 0; i < n; i++) begin
      stim_a[i] = (kind == 0) ? 31 : i;
      stim_b[i] = (kind == 0) ? 31 : i;
    end
  endtask

  initial begin
    int asc_v[8]  = '{2, 4, 6, 6, 8, 8, 10, 12};
    int asc_i[8]  = '{0, 1, 2, 6, 3, 7, 4, 5};
    int desc_v[8] = '{12, 10, 8, 8, 6, 6, 4, 2};
    int desc_i[8] = '{5, 4, 3, 7, 2, 6, 1, 0};
    int hi;
    rst0 = 1'b1; rst1 = 1'b1;
    drive(0, 1'b0, 0, 0, 0, 0);
    drive(1, 1'b0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0;
    chk_en = 1'b1;
    check("rst_out_valid", 0, 32'(ov0), 0);
    check("rst_out", 0, 32'(out0), 0);
    check("rst_in_ready", 0, 32'(rdy0), 1);
    check("rst_in_ready", 1, 32'(rdy1), 1);

    fill(8, 0);
    run_frame(0, 0, 0, 0, -1, 0, -1, 0, 1'b0, -1, 10);
    check("model_all31_first", 0, m_val[0][0], 62);
    check("model_all31_last", 0, m_val[0][7], 62);

    fill(8, 1);
    run_frame(0, 0, 0, 0, -1, 0, -1, 0, 1'b0, -1, 10);
    for (int i = 0; i < 8; i++) check("model_ramp", 0, m_val[0][i], 2 * i);

    run_frame(0, 3, 1, 0, -1, 0, -1, 0, 1'b0, -1, 10);
    for (int i = 0; i < 8; i++) begin
      check("model_rot_asc_val", 0, m_val[0][i], asc_v[i]);
      check("model_rot_asc_idx", 0, m_idx[0][i], asc_i[i]);
    end

    run_frame(0, 3, 1, 1, -1, 0, -1, 0, 1'b0, -1, 10);
    for (int i = 0; i < 8; i++) begin
      check("model_rot_desc_val", 0, m_val[0][i], desc_v[i]);
      check("model_rot_desc_idx", 0, m_idx[0][i], desc_i[i]);
    end

    // Gaps inside both rings, in_valid held high through OUT.
    run_frame(0, 3, 1, 0, 3, 3, 5, 2, 1'b1, -1, 10);

    // Reset pulsed during SORT with in_valid high, then a clean all-31 frame.
    run_frame(0, 3, 1, 0, -1, 0, -1, 0, 1'b0, 3, 0);
    fill(8, 0);
    run_frame(0, 0, 0, 0, -1, 0, -1, 0, 1'b0, -1, 10);

    for (int f = 0; f < 200; f++) begin
      hi = (f % 2 == 0) ? 255 : 3;
      for (int i = 0; i < 16; i++) begin
        stim_a[i] = int'($urandom_range(0, hi));
        stim_b[i] = int'($urandom_range(0, hi));
      end
      if (f % 5 == 0)
        run_frame(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)), int'($urandom_range(1, 3)),
                  int'($urandom_range(0, 15)), int'($urandom_range(1, 3)), 1'b0, -1, 18);
      else
        run_frame(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                  -1, 0, -1, 0, 1'b0, -1, 18);
    end

    repeat (4) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
